// File: rtl/adder_tree_pipe.sv
// Pipelined pairwise reduction of two packed vectors with a valid/ready stream,
// optional signed elements and optional per-frame accumulation of the totals.
module adder_tree_pipe #(
  parameter int TREE_SIZE = 8,
  parameter int DATA_SIZE = 8,
  parameter bit SIGNED    = 1'b0,
  parameter bit ACCUM     = 1'b0,
  parameter int ACC_WIDTH = DATA_SIZE + $clog2(TREE_SIZE) + 9,
  localparam int TW       = DATA_SIZE + $clog2(TREE_SIZE) + 1,
  localparam int ZW       = ACCUM ? ACC_WIDTH : TW
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [TREE_SIZE*DATA_SIZE-1:0] A,
  input  logic [TREE_SIZE*DATA_SIZE-1:0] B,
  input  logic                           in_valid,
  input  logic                           in_last,
  output logic                           in_ready,
  output logic [ZW-1:0]                  Z,
  output logic                           out_valid,
  input  logic                           out_ready
);

  localparam int K     = $clog2(TREE_SIZE);
  localparam int NODES = 2 * TREE_SIZE - 1;
  localparam int ROOT  = NODES - 1;

  // Levels are packed back to back: pair sums at 0, then each halved level after it.
  function automatic int lvl_off(input int j);
    return 2 * TREE_SIZE - ((2 * TREE_SIZE) >> j);
  endfunction

  function automatic logic [TW-1:0] ext_elem(input logic [DATA_SIZE-1:0] e);
    logic [TW-1:0] r;
    r = TW'(e);
    if (SIGNED && e[DATA_SIZE-1]) r = r | ~TW'({DATA_SIZE{1'b1}});
    return r;
  endfunction

  logic            advance;
  logic [TW-1:0]   node_q [NODES];
  logic [K:0]      vld_q, vld_d;
  logic [K:0]      last_q, last_d;
  logic [ZW-1:0]   z_q, z_d;
  logic            out_valid_q, out_valid_d;
  logic            first_q, first_d;
  logic [ZW-1:0]   tree_ext;
  logic [ZW-1:0]   acc_base;

  assign advance   = !out_valid_q || out_ready;
  assign in_ready  = advance;
  assign Z         = z_q;
  assign out_valid = out_valid_q;

  // NOTE: the tree datapath carries no reset; only the valid/last bits and O need
  // a defined value, and invalid stage contents never reach O.
  always_ff @(posedge clk) begin
    if (advance) begin
      for (int i = 0; i < TREE_SIZE; i++) begin
        node_q[i] <= ext_elem(A[i*DATA_SIZE +: DATA_SIZE]) +
                     ext_elem(B[i*DATA_SIZE +: DATA_SIZE]);
      end
      for (int j = 1; j <= K; j++) begin
        for (int i = 0; i < (TREE_SIZE >> j); i++) begin
          node_q[lvl_off(j) + i] <= node_q[lvl_off(j-1) + 2*i] +
                                    node_q[lvl_off(j-1) + 2*i + 1];
        end
      end
    end
  end

  always_comb begin
    tree_ext = ZW'(node_q[ROOT]);
    if (SIGNED && node_q[ROOT][TW-1]) tree_ext = tree_ext | ~ZW'({TW{1'b1}});
  end

  assign acc_base = (ACCUM && !first_q) ? z_q : '0;

  always_comb begin
    // NOTE: defaults first, so every path assigns every output and no latch is inferred.
    vld_d       = vld_q;
    last_d      = last_q;
    z_d         = z_q;
    out_valid_d = out_valid_q;
    first_d     = first_q;
    if (advance) begin
      vld_d       = {vld_q[K-1:0], in_valid};
      last_d      = {last_q[K-1:0], in_valid && in_last};
      out_valid_d = 1'b0;
      if (vld_q[K]) begin
        z_d         = acc_base + tree_ext;
        out_valid_d = ACCUM ? last_q[K] : 1'b1;
        first_d     = last_q[K];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q       <= '0;
      last_q      <= '0;
      z_q         <= '0;
      out_valid_q <= 1'b0;
      first_q     <= 1'b1;
    end else begin
      vld_q       <= vld_d;
      last_q      <= last_d;
      z_q         <= z_d;
      out_valid_q <= out_valid_d;
      first_q     <= first_d;
    end
  end

endmodule

// File: tb/tb_adder_tree_pipe.sv
// Directed bench for adder_tree_pipe: unsigned, signed and accumulating instances
// share one stimulus stream; each scenario task checks its own expected values.
module tb_adder_tree_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] a_in, b_in;
  logic        in_valid, in_last, out_ready;

  logic        in_ready_u, in_ready_s, in_ready_a;
  logic        out_valid_u, out_valid_s, out_valid_a;
  logic [11:0] z_u, z_s;
  logic [19:0] z_a;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  adder_tree_pipe #(.TREE_SIZE(8), .DATA_SIZE(8), .SIGNED(1'b0), .ACCUM(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .A(a_in), .B(b_in), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready_u), .Z(z_u), .out_valid(out_valid_u), .out_ready(out_ready));

  adder_tree_pipe #(.TREE_SIZE(8), .DATA_SIZE(8), .SIGNED(1'b1), .ACCUM(1'b0)) u_sgn (
    .clk(clk), .rst_n(rst_n), .A(a_in), .B(b_in), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready_s), .Z(z_s), .out_valid(out_valid_s), .out_ready(out_ready));

  adder_tree_pipe #(.TREE_SIZE(8), .DATA_SIZE(8), .SIGNED(1'b0), .ACCUM(1'b1)) u_acc (
    .clk(clk), .rst_n(rst_n), .A(a_in), .B(b_in), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready_a), .Z(z_a), .out_valid(out_valid_a), .out_ready(out_ready));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_in     = '0;
    b_in     = '0;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    out_ready = 1'b1;
    idle_inputs();
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic set_beat(input logic [7:0] a0, input logic [7:0] b0,
                          input logic [7:0] a1, input logic [7:0] b1, input logic last);
    a_in       = '0;
    b_in       = '0;
    a_in[7:0]  = a0;
    a_in[15:8] = a1;
    b_in[7:0]  = b0;
    b_in[15:8] = b1;
    in_valid   = 1'b1;
    in_last    = last;
  endtask

  // Sends the beat already on a_in/b_in and returns just after the edge that loads O.
  task automatic run_one();
    in_valid = 1'b1;
    step();
    idle_inputs();
    for (int e = 2; e <= 5; e++) step();
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (out_valid_u !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid_u: got %b want 0", out_valid_u); end
    n_cmp++; if (out_valid_a !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid_a: got %b want 0", out_valid_a); end
    n_cmp++; if (z_u !== 12'd0) begin n_bad++; $display("FAIL reset_z_u: got %0d want 0", z_u); end
    n_cmp++; if (z_a !== 20'd0) begin n_bad++; $display("FAIL reset_z_a: got %0d want 0", z_a); end
    n_cmp++; if (in_ready_u !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready_u: got %b want 1", in_ready_u); end
    n_cmp++; if (in_ready_a !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready_a: got %b want 1", in_ready_a); end
  endtask

  // Accept edge counts as edge 1; out_valid must rise on edge 5 only and last one cycle.
  task automatic test_latency();
    do_reset();
    set_beat(8'd7, 8'd5, 8'd0, 8'd0, 1'b0);
    step();
    idle_inputs();
    for (int e = 2; e <= 6; e++) begin
      step();
      n_cmp++;
      if (out_valid_u !== (e == 5)) begin
        n_bad++; $display("FAIL latency_out_valid_edge%0d: got %b want %b", e, out_valid_u, (e == 5));
      end
      if (e == 5) begin
        n_cmp++;
        if (z_u !== 12'd12) begin n_bad++; $display("FAIL latency_z: got %0d want 12", z_u); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] exp_z [4];
    exp_z = '{12'd12, 12'd168, 12'd79, 12'd769};
    do_reset();
    set_beat(8'd7,   8'd5,   8'd0,   8'd0,   1'b0); step();
    set_beat(8'd123, 8'd45,  8'd0,   8'd0,   1'b0); step();
    set_beat(8'd16,  8'd17,  8'd5,   8'd41,  1'b0); step();
    set_beat(8'd126, 8'd187, 8'd215, 8'd241, 1'b0); step();
    idle_inputs();
    for (int k = 0; k < 4; k++) begin
      step();
      n_cmp++;
      if (out_valid_u !== 1'b1 || z_u !== exp_z[k]) begin
        n_bad++; $display("FAIL b2b_beat%0d: got valid=%b z=%0d want valid=1 z=%0d", k, out_valid_u, z_u, exp_z[k]);
      end
    end
    step();
    n_cmp++;
    if (out_valid_u !== 1'b0) begin n_bad++; $display("FAIL b2b_tail_valid: got %b want 0", out_valid_u); end
  endtask

  task automatic test_extremes();
    do_reset();
    a_in = '1; b_in = '1;
    run_one();
    n_cmp++; if (z_u !== 12'hFF0) begin n_bad++; $display("FAIL max_unsigned: got %h want ff0", z_u); end
    a_in = {8{8'h80}}; b_in = {8{8'h80}};
    run_one();
    n_cmp++; if (z_s !== 12'h800) begin n_bad++; $display("FAIL min_signed: got %h want 800", z_s); end
    set_beat(8'hFD, 8'h01, 8'h00, 8'h00, 1'b0);
    run_one();
    n_cmp++; if (z_s !== 12'hFFE) begin n_bad++; $display("FAIL neg_signed: got %h want ffe", z_s); end
    n_cmp++; if (z_u !== 12'h0FE) begin n_bad++; $display("FAIL neg_as_unsigned: got %h want 0fe", z_u); end
  endtask

  task automatic test_stall();
    logic [11:0] exp_z [6];
    logic [11:0] got [$];
    logic [11:0] prev_z;
    logic        prev_stall;
    logic        accept;
    int          sent;
    exp_z      = '{12'd11, 12'd22, 12'd33, 12'd44, 12'd55, 12'd66};
    sent       = 0;
    prev_stall = 1'b0;
    prev_z     = '0;
    do_reset();
    for (int c = 1; c <= 40; c++) begin
      out_ready = !(c >= 6 && c <= 8);
      idle_inputs();
      if (sent < 6) begin
        a_in[sent*8 +: 8] = 8'(10 * (sent + 1));
        b_in[56 +: 8]     = 8'(sent + 1);
        in_valid          = 1'b1;
      end
      #1;
      if (prev_stall) begin
        n_cmp++;
        if (out_valid_u !== 1'b1 || z_u !== prev_z) begin
          n_bad++; $display("FAIL stall_hold_c%0d: got valid=%b z=%0d want valid=1 z=%0d", c, out_valid_u, z_u, prev_z);
        end
      end
      if (c >= 6 && c <= 8) begin
        n_cmp++;
        if (in_ready_u !== 1'b0) begin n_bad++; $display("FAIL stall_in_ready_c%0d: got %b want 0", c, in_ready_u); end
      end
      accept     = in_valid && in_ready_u;
      prev_stall = out_valid_u && !out_ready;
      prev_z     = z_u;
      if (out_valid_u && out_ready) got.push_back(z_u);
      step();
      if (accept) sent++;
    end
    out_ready = 1'b1;
    n_cmp++;
    if (got.size() != 6) begin n_bad++; $display("FAIL stall_count: got %0d results want 6", got.size()); end
    for (int k = 0; k < 6; k++) begin
      if (k < got.size()) begin
        n_cmp++;
        if (got[k] !== exp_z[k]) begin n_bad++; $display("FAIL stall_order%0d: got %0d want %0d", k, got[k], exp_z[k]); end
      end
    end
  endtask

  task automatic test_accum();
    logic [19:0] got [$];
    do_reset();
    set_beat(8'd7,   8'd5,   8'd0,   8'd0,   1'b0); step();
    set_beat(8'd16,  8'd17,  8'd5,   8'd41,  1'b0); step();
    set_beat(8'd126, 8'd187, 8'd215, 8'd241, 1'b1); step();
    set_beat(8'd123, 8'd45,  8'd0,   8'd0,   1'b1); step();
    idle_inputs();
    for (int c = 0; c < 12; c++) begin
      step();
      if (out_valid_a) got.push_back(z_a);
    end
    n_cmp++;
    if (got.size() != 2) begin n_bad++; $display("FAIL accum_count: got %0d outputs want 2", got.size()); end
    if (got.size() >= 1) begin
      n_cmp++; if (got[0] !== 20'd860) begin n_bad++; $display("FAIL accum_frame1: got %0d want 860", got[0]); end
    end
    if (got.size() >= 2) begin
      n_cmp++; if (got[1] !== 20'd168) begin n_bad++; $display("FAIL accum_one_beat: got %0d want 168", got[1]); end
    end
  endtask

  task automatic test_reset_midstream();
    int stale;
    do_reset();
    set_beat(8'd7, 8'd5, 8'd0, 8'd0, 1'b0); step();
    for (int e = 2; e <= 6; e++) begin
      set_beat(8'd123, 8'd45, 8'd0, 8'd0, 1'b0);
      step();
    end
    n_cmp++;
    if (out_valid_u !== 1'b1 || z_u !== 12'd168) begin
      n_bad++; $display("FAIL midrst_pre: got valid=%b z=%0d want valid=1 z=168", out_valid_u, z_u);
    end
    rst_n = 1'b0;
    idle_inputs();
    #1;
    n_cmp++; if (out_valid_u !== 1'b0) begin n_bad++; $display("FAIL midrst_out_valid: got %b want 0", out_valid_u); end
    n_cmp++; if (z_u !== 12'd0) begin n_bad++; $display("FAIL midrst_z_u: got %0d want 0", z_u); end
    n_cmp++; if (z_a !== 20'd0) begin n_bad++; $display("FAIL midrst_z_a: got %0d want 0", z_a); end
    step();
    step();
    rst_n = 1'b1;
    stale = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (out_valid_u || out_valid_a) stale++;
    end
    n_cmp++; if (stale != 0) begin n_bad++; $display("FAIL midrst_stale: got %0d stale outputs want 0", stale); end
    set_beat(8'd7, 8'd5, 8'd0, 8'd0, 1'b1);
    run_one();
    n_cmp++;
    if (out_valid_u !== 1'b1 || z_u !== 12'd12) begin
      n_bad++; $display("FAIL midrst_new_u: got valid=%b z=%0d want valid=1 z=12", out_valid_u, z_u);
    end
    n_cmp++;
    if (out_valid_a !== 1'b1 || z_a !== 20'd12) begin
      n_bad++; $display("FAIL midrst_new_a: got valid=%b z=%0d want valid=1 z=12", out_valid_a, z_a);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    out_ready = 1'b1;
    idle_inputs();
    test_reset();
    test_latency();
    test_back_to_back();
    test_extremes();
    test_stall();
    test_accum();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
